// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op selects, destination
// selects and the multiply/divide sequencer states.
package ex_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_SLTU  = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_LUI   = 4'd11;
    localparam logic [3:0] OP_MULTU = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_MFHI  = 4'd14;
    localparam logic [3:0] OP_MFLO  = 4'd15;

    localparam logic [1:0] RD_RT   = 2'd0;
    localparam logic [1:0] RD_RD   = 2'd1;
    localparam logic [1:0] RD_RA   = 2'd2;
    localparam logic [1:0] RD_ZERO = 2'd3;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2
    } md_state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_stage_muldiv_unit.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit
// per cycle over 32 cycles, with the architectural HI/LO registers.
//
// state   | meaning
// MD_IDLE | no operation in flight; HI/LO stable
// MD_MUL  | shift-add multiply, one multiplier bit per cycle
// MD_DIV  | restoring divide, one quotient bit per cycle
module muldiv_unit (
    input  logic        clock,
    input  logic        rst,
    input  logic [3:0]  opsel,
    input  logic        ex_new,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    import ex_pkg::*;

    md_state_t   state, state_nxt;
    logic [4:0]  cnt;
    logic        issued;
    logic        start;
    logic        last;
    logic [31:0] work_hi, work_lo, work_b;
    logic [31:0] step_hi, step_lo;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_rem;

    // issued blocks a held instruction from re-launching once it has run
    assign start = is_muldiv(opsel) && (state == MD_IDLE) && (ex_new || !issued);
    assign last  = (cnt == 5'd31);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) state <= MD_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start) state_nxt = (opsel == OP_MULTU) ? MD_MUL : MD_DIV;
            MD_MUL,
            MD_DIV:  if (last) state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != MD_IDLE);
    end

    assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, work_b} : 33'd0);
    assign div_shift = {work_hi, work_lo[31]};
    assign div_ge    = (div_shift >= {1'b0, work_b});
    // when div_ge holds the difference is below the divisor, so 32 bits suffice
    assign div_rem   = div_shift[31:0] - work_b;

    always_comb begin
        step_hi = work_hi;
        step_lo = work_lo;
        case (state)
            MD_MUL: begin
                step_hi = mul_sum[32:1];
                step_lo = {mul_sum[0], work_lo[31:1]};
            end
            MD_DIV: begin
                step_hi = div_ge ? div_rem : div_shift[31:0];
                step_lo = {work_lo[30:0], div_ge};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            issued  <= 1'b0;
            work_hi <= '0;
            work_lo <= '0;
            work_b  <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (start)       issued <= 1'b1;
            else if (ex_new) issued <= 1'b0;

            if (start) begin
                cnt     <= '0;
                work_hi <= '0;
                work_lo <= op_a;
                work_b  <= op_b;
            end else if (state != MD_IDLE) begin
                work_hi <= step_hi;
                work_lo <= step_lo;
                cnt     <= cnt + 5'd1;
                if (last) begin
                    hi <= step_hi;
                    lo <= step_lo;
                end
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, destination select
// and the pipeline bubble while a multiply/divide result is pending.
module ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             WB,
    input  logic             RegWrite,
    input  logic             MRead,
    input  logic             MWrite,
    input  logic [3:0]       OPSEL,
    input  logic             BSRC,
    input  logic [5:0]       aluControl,
    input  logic [1:0]       RegDst,
    input  logic [4:0]       RegRs,
    input  logic [4:0]       RegRt,
    input  logic [4:0]       RegRd,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    input  logic [WIDTH-1:0] imm_value,
    input  logic             ex_new,
    input  logic             exmem_RegWrite,
    input  logic             memwb_RegWrite,
    input  logic [4:0]       exmem_Rd,
    input  logic [4:0]       memwb_Rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic [WIDTH-1:0] memwb_result,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] store_data,
    output logic [4:0]       dest_reg,
    output logic             overflow,
    output logic             md_stall,
    output logic             WB_o,
    output logic             RegWrite_o,
    output logic             MRead_o,
    output logic             MWrite_o
);
    import ex_pkg::*;

    logic [WIDTH-1:0] fwd_a, fwd_b, op_b;
    logic [WIDTH-1:0] add_res, sub_res;
    logic [WIDTH-1:0] hi, lo;
    logic [4:0]       shamt;
    logic             busy;

    // EX/MEM wins over MEM/WB; r0 is never forwarded
    always_comb begin
        fwd_a = DataA;
        if (exmem_RegWrite && exmem_Rd != 5'd0 && exmem_Rd == RegRs)
            fwd_a = exmem_result;
        else if (memwb_RegWrite && memwb_Rd != 5'd0 && memwb_Rd == RegRs)
            fwd_a = memwb_result;
    end

    always_comb begin
        fwd_b = DataB;
        if (exmem_RegWrite && exmem_Rd != 5'd0 && exmem_Rd == RegRt)
            fwd_b = exmem_result;
        else if (memwb_RegWrite && memwb_Rd != 5'd0 && memwb_Rd == RegRt)
            fwd_b = memwb_result;
    end

    assign store_data = fwd_b;
    assign op_b       = BSRC ? imm_value : fwd_b;
    assign shamt      = aluControl[5] ? fwd_a[4:0] : aluControl[4:0];
    assign add_res    = fwd_a + op_b;
    assign sub_res    = fwd_a - op_b;

    muldiv_unit u_muldiv (
        .clock  (clock),
        .rst    (rst),
        .opsel  (OPSEL),
        .ex_new (ex_new),
        .op_a   (fwd_a),
        .op_b   (op_b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always_comb begin
        alu_result = '0;
        overflow   = 1'b0;
        case (OPSEL)
            OP_ADD: begin
                alu_result = add_res;
                overflow   = (fwd_a[WIDTH-1] == op_b[WIDTH-1]) &&
                             (add_res[WIDTH-1] != fwd_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = sub_res;
                overflow   = (fwd_a[WIDTH-1] != op_b[WIDTH-1]) &&
                             (sub_res[WIDTH-1] != fwd_a[WIDTH-1]);
            end
            OP_AND:   alu_result = fwd_a & op_b;
            OP_OR:    alu_result = fwd_a | op_b;
            OP_XOR:   alu_result = fwd_a ^ op_b;
            OP_NOR:   alu_result = ~(fwd_a | op_b);
            OP_SLT:   alu_result = {{(WIDTH-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
            OP_SLTU:  alu_result = {{(WIDTH-1){1'b0}}, fwd_a < op_b};
            OP_SLL:   alu_result = op_b << shamt;
            OP_SRL:   alu_result = op_b >> shamt;
            OP_SRA:   alu_result = $signed(op_b) >>> shamt;
            OP_LUI:   alu_result = {op_b[15:0], 16'h0000};
            OP_MFHI:  alu_result = hi;
            OP_MFLO:  alu_result = lo;
            default:  alu_result = '0;
        endcase
    end

    assign md_stall   = busy && (OPSEL >= OP_MULTU);
    assign WB_o       = WB && !md_stall;
    assign MRead_o    = MRead && !md_stall;
    assign MWrite_o   = MWrite && !md_stall;
    // MULTU/DIVU write HI/LO, never the register file
    assign RegWrite_o = RegWrite && !md_stall && !is_muldiv(OPSEL);

    always_comb begin
        case (RegDst)
            RD_RT:   dest_reg = RegRt;
            RD_RD:   dest_reg = RegRd;
            RD_RA:   dest_reg = 5'd31;
            RD_ZERO: dest_reg = 5'd0;
            default: dest_reg = 5'd0;
        endcase
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed plus randomized bench for ex_stage with an arithmetic reference
// model for the ALU, forwarding and multiply/divide results.
module tb_ex_stage;

    logic        clock, rst;
    logic        WB, RegWrite, MRead, MWrite;
    logic [3:0]  OPSEL;
    logic        BSRC;
    logic [5:0]  aluControl;
    logic [1:0]  RegDst;
    logic [4:0]  RegRs, RegRt, RegRd;
    logic [31:0] DataA, DataB, imm_value;
    logic        ex_new;
    logic        exmem_RegWrite, memwb_RegWrite;
    logic [4:0]  exmem_Rd, memwb_Rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_result, store_data;
    logic [4:0]  dest_reg;
    logic        overflow, md_stall, WB_o, RegWrite_o, MRead_o, MWrite_o;

    int n_cmp = 0;
    int n_err = 0;

    ex_stage #(.WIDTH(32)) dut (
        .clock(clock), .rst(rst),
        .WB(WB), .RegWrite(RegWrite), .MRead(MRead), .MWrite(MWrite),
        .OPSEL(OPSEL), .BSRC(BSRC), .aluControl(aluControl), .RegDst(RegDst),
        .RegRs(RegRs), .RegRt(RegRt), .RegRd(RegRd),
        .DataA(DataA), .DataB(DataB), .imm_value(imm_value),
        .ex_new(ex_new),
        .exmem_RegWrite(exmem_RegWrite), .memwb_RegWrite(memwb_RegWrite),
        .exmem_Rd(exmem_Rd), .memwb_Rd(memwb_Rd),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .alu_result(alu_result), .store_data(store_data), .dest_reg(dest_reg),
        .overflow(overflow), .md_stall(md_stall),
        .WB_o(WB_o), .RegWrite_o(RegWrite_o), .MRead_o(MRead_o), .MWrite_o(MWrite_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        WB = 0; RegWrite = 0; MRead = 0; MWrite = 0;
        OPSEL = 4'd0; BSRC = 0; aluControl = 6'd0; RegDst = 2'd0;
        RegRs = 0; RegRt = 0; RegRd = 0;
        DataA = 0; DataB = 0; imm_value = 0; ex_new = 0;
        exmem_RegWrite = 0; memwb_RegWrite = 0; exmem_Rd = 0; memwb_Rd = 0;
        exmem_result = 0; memwb_result = 0;
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] key, input logic [31:0] regval);
        if (exmem_RegWrite && exmem_Rd != 0 && exmem_Rd == key) return exmem_result;
        if (memwb_RegWrite && memwb_Rd != 0 && memwb_Rd == key) return memwb_result;
        return regval;
    endfunction

    // ALU reference in plain integer arithmetic
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [5:0] ctl,
                                           output logic ovf);
        longint s;
        int ia, ib, sh;
        ia = a; ib = b;
        sh = ctl[5] ? int'(a[4:0]) : int'(ctl[4:0]);
        ovf = 0;
        case (op)
            0: begin s = longint'(ia) + longint'(ib); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); return a + b; end
            1: begin s = longint'(ia) - longint'(ib); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); return a - b; end
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ~(a | b);
            6: return (ia < ib) ? 32'd1 : 32'd0;
            7: return (a < b) ? 32'd1 : 32'd0;
            8: return 32'(longint'(b) * (64'd1 << sh));
            9: return b / (32'd1 << sh);
            10: return 32'(ib >>> sh);
            11: return 32'(longint'(b) * 65536);
            default: return 32'd0;
        endcase
    endfunction

    // run MULTU/DIVU, follow with MFLO, count stall cycles, then read HI
    task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] prod;
        logic [31:0] exp_hi, exp_lo;
        int stalls;
        logic bubble_ok;
        if (op == 4'd12) begin
            prod = {32'd0, a} * {32'd0, b};
            exp_hi = prod[63:32]; exp_lo = prod[31:0];
        end else if (b == 0) begin
            exp_hi = a; exp_lo = 32'hFFFF_FFFF;
        end else begin
            exp_hi = a % b; exp_lo = a / b;
        end
        tick();
        clear_inputs();
        OPSEL = op; DataA = a; DataB = b; RegWrite = 1; ex_new = 1;
        #2;
        chk({tag, "_issue_regwrite"}, {31'd0, RegWrite_o}, 32'd0);
        chk({tag, "_issue_result"}, alu_result, 32'd0);
        tick();
        OPSEL = 4'd15; RegWrite = 1; WB = 1; MRead = 1; MWrite = 1; ex_new = 1;
        stalls = 0; bubble_ok = 1;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (!md_stall) break;
            stalls++;
            if (RegWrite_o || WB_o || MRead_o || MWrite_o) bubble_ok = 0;
            tick();
            ex_new = 0;
        end
        chk({tag, "_stall_cycles"}, stalls, 32'd32);
        chk({tag, "_bubble"}, {31'd0, bubble_ok}, 32'd1);
        chk({tag, "_lo"}, alu_result, exp_lo);
        chk({tag, "_mflo_regwrite"}, {31'd0, RegWrite_o}, 32'd1);
        OPSEL = 4'd14;
        #1;
        chk({tag, "_hi"}, alu_result, exp_hi);
    endtask

    initial begin
        logic [31:0] ea, eb, eopb, exp_r;
        logic        eovf;
        int          stalls;
        logic        quiet;

        clear_inputs();
        rst = 1;
        #1;
        RegWrite = 1; MRead = 1; OPSEL = 4'd15;
        #2;
        chk("reset_md_stall", {31'd0, md_stall}, 32'd0);
        chk("reset_regwrite_pass", {31'd0, RegWrite_o}, 32'd1);
        chk("reset_mread_pass", {31'd0, MRead_o}, 32'd1);
        chk("reset_lo", alu_result, 32'd0);
        tick(); tick();
        rst = 0;
        OPSEL = 4'd14; #1;
        chk("reset_hi", alu_result, 32'd0);

        // forwarding directed cases
        tick(); clear_inputs(); ex_new = 1;
        RegRs = 3; exmem_RegWrite = 1; exmem_Rd = 3; exmem_result = 32'h10;
        DataA = 32'h5; BSRC = 1; imm_value = 4; OPSEL = 4'd0;
        #2; chk("addi_fwd", alu_result, 32'h14);

        tick(); clear_inputs(); ex_new = 1;
        RegRs = 7; exmem_RegWrite = 1; exmem_Rd = 7; exmem_result = 32'hA;
        memwb_RegWrite = 1; memwb_Rd = 7; memwb_result = 32'hB; OPSEL = 4'd3; BSRC = 1;
        #2; chk("fwd_priority", alu_result, 32'hA);
        exmem_RegWrite = 0; #1;
        chk("fwd_memwb", alu_result, 32'hB);

        tick(); clear_inputs(); ex_new = 1;
        RegRs = 0; exmem_RegWrite = 1; exmem_Rd = 0; exmem_result = 32'h99;
        DataA = 32'h1234; BSRC = 1;
        #2; chk("fwd_r0", alu_result, 32'h1234);

        tick(); clear_inputs(); ex_new = 1;
        DataA = 32'h7FFF_FFFF; BSRC = 1; imm_value = 1; OPSEL = 4'd0;
        #2; chk("add_ovf_result", alu_result, 32'h8000_0000);
        chk("add_ovf_flag", {31'd0, overflow}, 32'd1);
        DataA = 32'hFFFF_FFFF; OPSEL = 4'd6; #1;
        chk("slt", alu_result, 32'd1);
        chk("slt_no_ovf", {31'd0, overflow}, 32'd0);
        OPSEL = 4'd7; #1;
        chk("sltu", alu_result, 32'd0);
        RegRd = 5'd9; RegRt = 5'd4;
        RegDst = 2'd2; #1; chk("dest_ra", dest_reg, 32'd31);
        RegDst = 2'd3; #1; chk("dest_zero", dest_reg, 32'd0);
        RegDst = 2'd1; #1; chk("dest_rd", dest_reg, 32'd9);

        run_md("multu_max", 4'd12, 32'hFFFF_FFFF, 32'd2);
        run_md("divu_100_7", 4'd13, 32'd100, 32'd7);
        run_md("divu_by0", 4'd13, 32'h55, 32'd0);
        for (int k = 0; k < 6; k++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 0;
                1: rb = $urandom_range(1, 1000);
                default: rb = $urandom;
            endcase
            run_md("md_rand", ($urandom_range(0, 1) == 1) ? 4'd12 : 4'd13, ra, rb);
        end

        // randomized ALU/forwarding sweep
        for (int k = 0; k < 40; k++) begin
            tick(); clear_inputs(); ex_new = 1;
            OPSEL = 4'($urandom_range(0, 11));
            WB = 1'($urandom); RegWrite = 1'($urandom); MRead = 1'($urandom); MWrite = 1'($urandom);
            BSRC = 1'($urandom); aluControl = 6'($urandom); RegDst = 2'($urandom);
            RegRs = 5'($urandom_range(0, 5)); RegRt = 5'($urandom_range(0, 5)); RegRd = 5'($urandom);
            DataA = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
            DataB = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            imm_value = $urandom;
            exmem_RegWrite = 1'($urandom); memwb_RegWrite = 1'($urandom);
            exmem_Rd = 5'($urandom_range(0, 5)); memwb_Rd = 5'($urandom_range(0, 5));
            exmem_result = $urandom; memwb_result = $urandom;
            #2;
            ea = ref_fwd(RegRs, DataA);
            eb = ref_fwd(RegRt, DataB);
            eopb = BSRC ? imm_value : eb;
            exp_r = ref_alu(OPSEL, ea, eopb, aluControl, eovf);
            chk("rand_alu", alu_result, exp_r);
            chk("rand_ovf", {31'd0, overflow}, {31'd0, eovf});
            chk("rand_store", store_data, eb);
            chk("rand_dest", dest_reg, (RegDst == 0) ? RegRt : (RegDst == 1) ? RegRd :
                                       (RegDst == 2) ? 5'd31 : 5'd0);
            chk("rand_regwrite", {31'd0, RegWrite_o}, {31'd0, RegWrite});
            chk("rand_mwrite", {31'd0, MWrite_o}, {31'd0, MWrite});
        end

        // reset in the middle of a MULTU: no HI/LO write may follow
        tick(); clear_inputs();
        OPSEL = 4'd12; DataA = 32'd3; DataB = 32'd5; ex_new = 1;
        tick();
        OPSEL = 4'd15; ex_new = 0; RegWrite = 1;
        repeat (10) tick();
        #1;
        chk("midop_busy_before_rst", {31'd0, md_stall}, 32'd1);
        rst = 1; #1;
        chk("midop_rst_stall", {31'd0, md_stall}, 32'd0);
        chk("midop_rst_regwrite", {31'd0, RegWrite_o}, 32'd1);
        tick();
        rst = 0;
        repeat (40) tick();
        #1;
        chk("midop_lo", alu_result, 32'd0);
        OPSEL = 4'd14; #1;
        chk("midop_hi", alu_result, 32'd0);

        // DIVU held in ID/EX must run exactly once
        tick(); clear_inputs();
        OPSEL = 4'd13; DataA = 32'd1000; DataB = 32'd10; ex_new = 1;
        tick();
        ex_new = 0;
        stalls = 0;
        for (int i = 0; i < 80; i++) begin
            #2;
            if (!md_stall) break;
            stalls++;
            tick();
        end
        chk("hold_stall_cycles", stalls, 32'd32);
        quiet = 1;
        for (int i = 0; i < 5; i++) begin
            tick(); #2;
            if (md_stall) quiet = 0;
        end
        chk("hold_no_restart", {31'd0, quiet}, 32'd1);
        OPSEL = 4'd15; #1;
        chk("hold_lo", alu_result, 32'd100);
        OPSEL = 4'd14; #1;
        chk("hold_hi", alu_result, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter: WIDTH, 32, datapath width; only 32 is supported.
REQ-002 clock  in  1  rising-edge clock.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 WB, RegWrite, MRead, MWrite  in  1 each  control fields from the ID/EX register.
REQ-005 OPSEL  in  4  operation select, encoding per REQ-013.
REQ-006 BSRC  in  1  selects the B operand: 1 = imm_value, 0 = forwarded rt.
REQ-007 aluControl  in  6  shift control: [5] = 1 means variable shift; [4:0] is the static shamt.
REQ-008 RegDst  in  2  destination select: 0 = Rt, 1 = Rd, 2 = 31, 3 = 0.
REQ-009 RegRs, RegRt, RegRd  in  5 each; DataA, DataB, imm_value  in  32 each.
REQ-010 ex_new  in  1  ID/EX captured a new instruction on the previous edge.
REQ-011 exmem_RegWrite, memwb_RegWrite  in  1; exmem_Rd, memwb_Rd  in  5; exmem_result, memwb_result  in  32  forwarding sources.
REQ-012 Outputs: alu_result 32, store_data 32, dest_reg 5, overflow 1, md_stall 1, and WB_o/RegWrite_o/MRead_o/MWrite_o 1 each to EX/MEM.

Function
REQ-013 OPSEL encoding:
- 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR; 5 NOR
- 6 SLT (signed); 7 SLTU; 8 SLL; 9 SRL; 10 SRA; 11 LUI (B<<16)
- 12 MULTU; 13 DIVU; 14 MFHI; 15 MFLO
REQ-014 Forwarding for A (key RegRs) and B (key RegRt):
- EX/MEM match: RegWrite=1, Rd!=0, Rd==key.
- EX/MEM match has priority over MEM/WB match.
- No match: use DataA/DataB.
REQ-015 store_data is forwarded B. Operand B is imm_value when BSRC=1, else forwarded B.
REQ-016 Shift amount is A[4:0] when aluControl[5]=1, else aluControl[4:0]. The shift operand is B.
REQ-017 overflow: signed two's-complement overflow for ADD/SUB only, 0 otherwise. It is a flag only, with no trap and no suppression.
REQ-018 The ALU path is combinational with zero latency. All arithmetic is modulo 2^32.
REQ-019 Mul/div FSM states:
- IDLE -> MUL or DIV on start.
- MUL/DIV: 5-bit counter, one bit per cycle, 32 cycles.
- Returns to IDLE on the edge with counter=31; HI/LO are written on that same edge.
REQ-020 start = (OPSEL is 12 or 13) AND state=IDLE AND (ex_new OR NOT issued).
- issued is set on start.
- issued is cleared on any ex_new cycle without start.
- An ID/EX hold therefore never restarts an operation.
REQ-021 Timing: start edge E0; busy=1 after E0 through E32; HI/LO valid after E32.
REQ-022 MULTU result: {HI,LO} = A*B unsigned.
REQ-023 DIVU result: LO = quotient, HI = remainder (restoring). If B=0: LO=0xFFFFFFFF, HI=A.
REQ-024 md_stall = busy AND OPSEL in 12..15. Combinational; it drives IDEXWrite and PC hold low upstream.
REQ-025 While md_stall=1, RegWrite_o, MRead_o, MWrite_o and WB_o are forced 0 (bubble). Otherwise these outputs pass their inputs through.
REQ-026 MFHI/MFLO with busy=0 return HI/LO. MULTU/DIVU themselves produce RegWrite_o=0 and alu_result=0.
REQ-027 dest_reg follows RegDst per REQ-008.

Reset
REQ-028 rst forces state IDLE, counter 0, issued 0, busy 0, HI 0, LO 0 immediately, including in mid-operation. An aborted operation never writes HI/LO.
REQ-029 Combinational outputs during reset follow their inputs, with md_stall=0.

Structure
REQ-030 Shared package ex_pkg holds:
- OPSEL localparams
- RegDst codes
- mul/div FSM state encoding
REQ-031 Sub-module muldiv_unit contains the FSM, counter, issued flag, HI/LO and the shift-add/restoring datapath. ex_stage holds forwarding, the ALU and output muxing.

Verification
REQ-032 ADDI forward: Rs=3, exmem Rd=3 result 0x10, DataA=0x5, BSRC=1, imm=4 -> alu_result=0x14.
REQ-033 Priority and r0:
- exmem and memwb both match Rs=7 (0xA vs 0xB) -> 0xA used.
- exmem_Rd=0, Rs=0 -> DataA used.
REQ-034 MULTU 0xFFFFFFFF*2, then MFLO next cycle:
- md_stall=1 for 32 cycles with outputs bubbled.
- Then alu_result=0xFFFFFFFE; HI=1.
REQ-035 DIVU 100/7 -> LO=14, HI=2. DIVU 0x55/0 -> LO=0xFFFFFFFF, HI=0x55.
REQ-036 Flags and compares:
- ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1.
- SLT 0xFFFFFFFF,1 -> 1.
- SLTU -> 0.
REQ-037 rst pulse at cycle 10 of a MULTU -> busy=0, HI=LO=0, no later HI/LO write. ID/EX held 5 cycles on a DIVU -> single 32-cycle operation.
